// File: rtl/dense_argmax_if.sv
// Handshake/score bus between the dense stage, dense_argmax and the result register.
// maxScore exists only when ARGMAX_SCORE_OUT_EN is defined.
interface dense_argmax_if #(
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 16
);
  localparam int CW = $clog2(OUT_COUNT);

  logic                        start;
  logic                        inValid;
  logic signed [DATA_SIZE-1:0] dataIn;
  logic                        busy;
  logic                        valid;
  logic [CW-1:0]               classOut;
`ifdef ARGMAX_SCORE_OUT_EN
  logic signed [DATA_SIZE-1:0] maxScore;

  modport master (output start, inValid, dataIn, input busy, valid, classOut, maxScore);
  modport slave  (input start, inValid, dataIn, output busy, valid, classOut, maxScore);
`else
  modport master (output start, inValid, dataIn, input busy, valid, classOut);
  modport slave  (input start, inValid, dataIn, output busy, valid, classOut);
`endif
endinterface

// File: rtl/dense_argmax.sv
// Streaming argmax over OUT_COUNT signed scores; ties resolve to the lowest index.
// ARGMAX_SCORE_OUT_EN adds the registered winning-score output (maxScore).
module dense_argmax #(
  parameter int OUT_COUNT = 10,
  parameter int DATA_SIZE = 16
) (
  input  logic           clk,
  input  logic           rst,
  dense_argmax_if.slave  bus
);
  localparam int CW = $clog2(OUT_COUNT);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic signed [DATA_SIZE-1:0] run_max;
  logic [CW-1:0]               run_idx;

  // Fold the current score in combinationally so the final one lands in classOut directly.
  logic                        take;
  logic signed [DATA_SIZE-1:0] nxt_max;
  logic [CW-1:0]               nxt_idx;
  logic                        last;

  always_comb begin
    take    = (cnt == '0) || (bus.dataIn > run_max);
    nxt_max = take ? bus.dataIn : run_max;
    nxt_idx = take ? cnt : run_idx;
    last    = (cnt == CW'(OUT_COUNT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      run_max      <= '0;
      run_idx      <= '0;
      bus.busy     <= 1'b0;
      bus.valid    <= 1'b0;
      bus.classOut <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
      bus.maxScore <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= COLLECT;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        COLLECT: begin
          if (bus.inValid) begin
            run_max <= nxt_max;
            run_idx <= nxt_idx;
            if (last) begin
              state        <= DONE;
              bus.busy     <= 1'b0;
              bus.valid    <= 1'b1;
              bus.classOut <= nxt_idx;
`ifdef ARGMAX_SCORE_OUT_EN
              bus.maxScore <= nxt_max;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          bus.valid <= 1'b0;
          if (bus.start) begin
            state    <= COLLECT;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          bus.busy  <= 1'b0;
          bus.valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
